// File: rtl/mem_io_sequencer.sv
// rtl/mem_io_sequencer.sv - data-side load/store sequencer between CPU/loader and the Mem/IO mux
module mem_io_sequencer #(
    parameter int          MEM_LAT    = 1,
    parameter int          IO_TIMEOUT = 15,
    parameter logic [31:0] LED_ADDR   = 32'hFFFFFC60,
    parameter logic [31:0] SW_ADDR    = 32'hFFFFFC70,
    parameter logic [31:0] SW2_ADDR   = 32'hFFFFFC74,
    parameter logic [31:0] SEG_ADDR   = 32'hFFFFFC80,
    parameter logic [31:0] IO_BASE    = 32'hFFFFFC00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    input  logic        ldr_req,
    input  logic [31:0] ldr_addr,
    input  logic [31:0] ldr_wdata,
    output logic        ldr_done,
    output logic        mRead,
    output logic        mWrite,
    output logic        ioRead,
    output logic        ioWrite,
    output logic        ioRead2,
    output logic        ioWrite2,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] m_rdata,
    input  logic [7:0]  io_rdata,
    input  logic [7:0]  io_rdata2,
    input  logic        io_ack,
    output logic        bus_err
);

    localparam int CNT_MAX = (MEM_LAT > IO_TIMEOUT) ? MEM_LAT : IO_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_MEM,
        S_IO,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        DEV_LED,
        DEV_SW,
        DEV_SW2,
        DEV_SEG
    } dev_t;

    state_t        state;
    state_t        state_nx;
    logic          owner_ldr;
    logic          acc_we;
    logic          err_flag;
    dev_t          dev;
    logic [CW-1:0] cnt;

    logic          in_io;
    logic          dec_err;
    dev_t          dec_dev;
    logic          cpu_in_io;
    logic          ldr_in_io;
    logic          mem_last;
    logic          io_timeout;

    assign in_io      = (bus_addr[31:10] == IO_BASE[31:10]);
    assign cpu_in_io  = (cpu_addr[31:10] == IO_BASE[31:10]);
    assign ldr_in_io  = (ldr_addr[31:10] == IO_BASE[31:10]);
    assign mem_last   = (cnt == CW'(1));
    assign io_timeout = (cnt == CW'(IO_TIMEOUT));

    // Decode runs on the latched address so the grant cycle sees no decode logic.
    always_comb begin
        dec_err = 1'b0;
        dec_dev = DEV_LED;
        if (in_io) begin
            if (owner_ldr) begin
                dec_err = 1'b1;
            end else if (bus_addr == LED_ADDR && acc_we) begin
                dec_dev = DEV_LED;
            end else if (bus_addr == SW_ADDR && !acc_we) begin
                dec_dev = DEV_SW;
            end else if (bus_addr == SW2_ADDR && !acc_we) begin
                dec_dev = DEV_SW2;
            end else if (bus_addr == SEG_ADDR && acc_we) begin
                dec_dev = DEV_SEG;
            end else begin
                dec_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (ldr_req || cpu_req) begin
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_err) begin
                    state_nx = S_DONE;
                end else if (in_io) begin
                    state_nx = S_IO;
                end else begin
                    state_nx = S_MEM;
                end
            end
            S_MEM: begin
                if (mem_last) begin
                    state_nx = S_DONE;
                end
            end
            S_IO: begin
                if (io_ack || io_timeout) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_ldr <= 1'b0;
            acc_we    <= 1'b0;
            err_flag  <= 1'b0;
            dev       <= DEV_LED;
            cnt       <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            cpu_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    err_flag <= 1'b0;
                    if (ldr_req) begin
                        owner_ldr <= 1'b1;
                        acc_we    <= 1'b1;
                        bus_addr  <= ldr_addr;
                        bus_wdata <= ldr_in_io ? {24'b0, ldr_wdata[7:0]} : ldr_wdata;
                    end else if (cpu_req) begin
                        owner_ldr <= 1'b0;
                        acc_we    <= cpu_we;
                        bus_addr  <= cpu_addr;
                        bus_wdata <= cpu_in_io ? {24'b0, cpu_wdata[7:0]} : cpu_wdata;
                    end
                end
                S_DECODE: begin
                    err_flag <= dec_err;
                    dev      <= dec_dev;
                    cnt      <= in_io ? CW'(1) : CW'(MEM_LAT);
                end
                S_MEM: begin
                    cnt <= cnt - CW'(1);
                    if (mem_last && !acc_we && !owner_ldr) begin
                        cpu_rdata <= m_rdata;
                    end
                end
                S_IO: begin
                    cnt <= cnt + CW'(1);
                    if (io_ack) begin
                        if (!acc_we) begin
                            cpu_rdata <= {24'b0, (dev == DEV_SW2) ? io_rdata2 : io_rdata};
                        end
                    end else if (io_timeout) begin
                        err_flag <= 1'b1;
                        if (!acc_we) begin
                            cpu_rdata <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Strobes decode from registered state only, so they are one-hot and glitch-free by construction.
    assign mRead    = (state == S_MEM) && !acc_we;
    assign mWrite   = (state == S_MEM) && acc_we;
    assign ioRead   = (state == S_IO) && (dev == DEV_SW);
    assign ioRead2  = (state == S_IO) && (dev == DEV_SW2);
    assign ioWrite  = (state == S_IO) && (dev == DEV_LED);
    assign ioWrite2 = (state == S_IO) && (dev == DEV_SEG);

    assign cpu_done  = (state == S_DONE) && !owner_ldr;
    assign ldr_done  = (state == S_DONE) && owner_ldr;
    assign bus_err   = (state == S_DONE) && err_flag;
    assign cpu_stall = (cpu_req && !cpu_done) || (owner_ldr && state != S_IDLE);

endmodule

// File: tb/tb_mem_io_sequencer.sv
// tb/tb_mem_io_sequencer.sv - randomized self-checking bench for mem_io_sequencer
module tb_mem_io_sequencer;

    localparam int          MEM_LAT    = 1;
    localparam int          IO_TIMEOUT = 15;
    localparam logic [31:0] LED_A      = 32'hFFFFFC60;
    localparam logic [31:0] SW_A       = 32'hFFFFFC70;
    localparam logic [31:0] SW2_A      = 32'hFFFFFC74;
    localparam logic [31:0] SEG_A      = 32'hFFFFFC80;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ldr_req, io_ack;
    logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata, m_rdata;
    logic [7:0]  io_rdata, io_rdata2;
    logic        cpu_stall, cpu_done, ldr_done, bus_err;
    logic [31:0] cpu_rdata, bus_addr, bus_wdata;
    logic        mRead, mWrite, ioRead, ioWrite, ioRead2, ioWrite2;
    logic [5:0]  st;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rdata;

    always #5 clock = ~clock;

    assign st = {ioWrite2, ioRead2, ioWrite, ioRead, mWrite, mRead};

    mem_io_sequencer #(.MEM_LAT(MEM_LAT), .IO_TIMEOUT(IO_TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_done(ldr_done),
        .mRead(mRead), .mWrite(mWrite), .ioRead(ioRead), .ioWrite(ioWrite),
        .ioRead2(ioRead2), .ioWrite2(ioWrite2),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .m_rdata(m_rdata), .io_rdata(io_rdata), .io_rdata2(io_rdata2),
        .io_ack(io_ack), .bus_err(bus_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Strobe index: 0 mRead, 1 mWrite, 2 ioRead, 3 ioWrite, 4 ioRead2, 5 ioWrite2, -1 faulted access.
    function automatic int model_strobe(input bit ldr, input bit we, input logic [31:0] addr);
        logic [31:0] io_addr [4] = '{LED_A, SW_A, SW2_A, SEG_A};
        bit          io_wr   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int          io_idx  [4] = '{3, 2, 4, 5};
        if ((addr >> 10) != (32'hFFFFFC00 >> 10)) return we ? 1 : 0;
        if (ldr) return -1;
        for (int i = 0; i < 4; i++)
            if (addr == io_addr[i] && we == io_wr[i]) return io_idx[i];
        return -1;
    endfunction

    // One CPU access; ack_d = strobe cycle in which the IO device acks (0 or >IO_TIMEOUT: never).
    task automatic run_txn(input string name, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] mdata,
                           input logic [7:0] sw, input logic [7:0] sw2, input int ack_d);
        int          s, lat, n_exp, done_at, hot_bad, stall_bad, stray, total;
        int          cnt [6];
        logic        exp_err, got_err;
        logic [31:0] got_rd, addr_seen, wd_seen, exp_wd;
        s       = model_strobe(1'b0, we, addr);
        exp_err = 1'b0;
        n_exp   = 0;
        if (s < 0) begin
            lat = 2; exp_err = 1'b1;
        end else if (s < 2) begin
            lat = 2 + MEM_LAT; n_exp = MEM_LAT;
            if (!we) exp_rdata = mdata;
        end else if (ack_d >= 1 && ack_d <= IO_TIMEOUT) begin
            lat = 2 + ack_d; n_exp = ack_d;
            if (!we) exp_rdata = {24'h0, (s == 4) ? sw2 : sw};
        end else begin
            lat = 2 + IO_TIMEOUT; n_exp = IO_TIMEOUT; exp_err = 1'b1;
            if (!we) exp_rdata = 32'h0;
        end
        exp_wd = (s >= 2) ? {24'h0, wdata[7:0]} : wdata;
        for (int i = 0; i < 6; i++) cnt[i] = 0;
        done_at = -1; hot_bad = 0; stall_bad = 0; stray = 0;
        got_err = 1'b0; got_rd = 32'h0; addr_seen = 32'h0; wd_seen = 32'h0;
        m_rdata = mdata; io_rdata = sw; io_rdata2 = sw2;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            @(negedge clock);
            if ($countones(st) > 1) hot_bad++;
            for (int i = 0; i < 6; i++) if (st[i]) cnt[i]++;
            if (st != 6'b0) begin
                addr_seen = bus_addr;
                wd_seen   = bus_wdata;
            end
            io_ack = (s >= 2 && st[s] && cnt[s] == ack_d);
            if (cpu_stall !== (c < lat)) stall_bad++;
            if (ldr_done) stray++;
            if (cpu_done) begin
                done_at = c; got_err = bus_err; got_rd = cpu_rdata;
            end else if (bus_err) begin
                stray++;
            end
            @(posedge clock);
            #1;
        end
        io_ack  = 1'b0;
        cpu_req = 1'b0;
        total = 0;
        for (int i = 0; i < 6; i++) total += cnt[i];
        check({name, ".latency"}, done_at, lat);
        check({name, ".bus_err"}, got_err, exp_err);
        check({name, ".rdata"}, got_rd, exp_rdata);
        check({name, ".strobe_cycles"}, total, n_exp);
        check({name, ".onehot"}, hot_bad, 0);
        check({name, ".stall"}, stall_bad, 0);
        check({name, ".stray"}, stray, 0);
        if (s >= 0) begin
            check({name, ".strobe_sel"}, cnt[s], n_exp);
            check({name, ".bus_addr"}, addr_seen, addr);
            if (we) check({name, ".bus_wdata"}, wd_seen, exp_wd);
        end
    endtask

    // Loader and CPU (memory load) request in the same cycle; loader must be served first.
    task automatic run_ldr_cpu(input string name, input logic [31:0] laddr, input logic [31:0] lwdata,
                               input logic [31:0] caddr, input logic [31:0] mdata);
        bit          lio;
        int          l_lat, c_lat, ldr_at, cpu_at, mw_cnt, stall_bad;
        logic        l_err;
        logic [31:0] c_rd, la_seen, lw_seen;
        lio   = (model_strobe(1'b1, 1'b1, laddr) < 0);
        l_lat = lio ? 2 : 2 + MEM_LAT;
        c_lat = l_lat + 3 + MEM_LAT;
        ldr_at = -1; cpu_at = -1; mw_cnt = 0; stall_bad = 0;
        l_err = 1'b0; c_rd = 32'h0; la_seen = 32'h0; lw_seen = 32'h0;
        m_rdata = mdata;
        ldr_req = 1'b1; ldr_addr = laddr; ldr_wdata = lwdata;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = caddr; cpu_wdata = 32'h0;
        for (int c = 0; c < 40 && cpu_at < 0; c++) begin
            @(negedge clock);
            if (ldr_done) begin ldr_at = c; l_err = bus_err; end
            if (cpu_done) begin cpu_at = c; c_rd = cpu_rdata; end
            if (mWrite && ldr_at < 0) begin mw_cnt++; la_seen = bus_addr; lw_seen = bus_wdata; end
            if (cpu_stall !== (c < c_lat)) stall_bad++;
            @(posedge clock);
            #1;
            if (ldr_at >= 0) ldr_req = 1'b0;
        end
        ldr_req = 1'b0;
        cpu_req = 1'b0;
        exp_rdata = mdata;
        check({name, ".ldr_latency"}, ldr_at, l_lat);
        check({name, ".ldr_err"}, l_err, lio);
        check({name, ".cpu_latency"}, cpu_at, c_lat);
        check({name, ".cpu_rdata"}, c_rd, mdata);
        check({name, ".ldr_mwrite"}, mw_cnt, lio ? 0 : MEM_LAT);
        check({name, ".stall"}, stall_bad, 0);
        if (!lio) begin
            check({name, ".ldr_addr"}, la_seen, laddr);
            check({name, ".ldr_wdata"}, lw_seen, lwdata);
        end
    endtask

    task automatic run_reset_mid_io();
        int stray;
        stray = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = SW_A; io_ack = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("rst.pre_strobe", st, 6'b000100);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rst.strobes", st, 6'b0);
        check("rst.cpu_done", cpu_done, 1'b0);
        check("rst.bus_addr", bus_addr, 32'h0);
        reset   = 1'b0;
        cpu_req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (cpu_done || ldr_done || bus_err || st != 6'b0) stray++;
        end
        check("rst.no_done", stray, 0);
        exp_rdata = 32'h0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cat, ack_d, k;
        bit          we;
        logic [31:0] addr;
        logic [31:0] io_list [4];
        io_list = '{LED_A, SW_A, SW2_A, SEG_A};
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        ldr_req = 1'b0; ldr_addr = 32'h0; ldr_wdata = 32'h0; io_ack = 1'b0;
        m_rdata = 32'h0; io_rdata = 8'h0; io_rdata2 = 8'h0;
        exp_rdata = 32'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset.strobes", st, 6'b0);
        check("reset.stall", cpu_stall, 1'b0);
        check("reset.done", {cpu_done, ldr_done, bus_err}, 3'b000);
        check("reset.bus_addr", bus_addr, 32'h0);
        check("reset.bus_wdata", bus_wdata, 32'h0);
        check("reset.cpu_rdata", cpu_rdata, 32'h0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        run_txn("ld_mem", 1'b0, 32'h00000010, 32'h0, 32'hDEADBEEF, 8'h00, 8'h00, 0);
        run_txn("ld_sw2", 1'b0, SW2_A, 32'h0, 32'h0BAD0BAD, 8'h11, 8'h85, 3);
        run_txn("st_led", 1'b1, LED_A, 32'h12345678, 32'h0, 8'h00, 8'h00, 0);
        run_txn("st_sw", 1'b1, SW_A, 32'hCAFEF00D, 32'h0, 8'h00, 8'h00, 1);
        run_txn("ld_unmap", 1'b0, 32'hFFFFFC90, 32'h0, 32'h55555555, 8'h00, 8'h00, 1);
        run_txn("ld_led", 1'b0, LED_A, 32'h0, 32'h0, 8'h00, 8'h00, 1);
        run_txn("st_seg_ack15", 1'b1, SEG_A, 32'hA5A5A5C3, 32'h0, 8'h00, 8'h00, IO_TIMEOUT);
        run_txn("ld_sw_ack1", 1'b0, SW_A, 32'h0, 32'h0, 8'hF0, 8'h0F, 1);
        run_txn("st_mem", 1'b1, 32'h00001234, 32'h87654321, 32'h0, 8'h00, 8'h00, 0);
        run_ldr_cpu("arb_mem", 32'h00000400, 32'h13572468, 32'h00000020, 32'h24681357);
        run_ldr_cpu("arb_io", SEG_A, 32'h000000FF, 32'h00000024, 32'h0F0F0F0F);
        run_reset_mid_io();

        for (int n = 0; n < 60; n++) begin
            cat   = $urandom_range(0, 7);
            ack_d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, IO_TIMEOUT + 3);
            case (cat)
                0: begin we = 1'b0; addr = $urandom & 32'h7FFFFFFC; end
                1: begin we = 1'b1; addr = $urandom & 32'h7FFFFFFC; end
                2: begin we = 1'b1; addr = LED_A; end
                3: begin we = 1'b0; addr = SW_A; end
                4: begin we = 1'b0; addr = SW2_A; end
                5: begin we = 1'b1; addr = SEG_A; end
                6: begin
                    k    = $urandom_range(0, 3);
                    addr = io_list[k];
                    we   = (k == 1 || k == 2);
                end
                default: begin
                    we   = $urandom_range(0, 1);
                    addr = 32'hFFFFFC90 + (($urandom % 220) * 4);
                end
            endcase
            run_txn("rand", we, addr, $urandom, $urandom, 8'($urandom), 8'($urandom), ack_d);
            if ($urandom_range(0, 3) == 0)
                run_ldr_cpu("rand_arb", $urandom & 32'h7FFFFFFC, $urandom, $urandom & 32'h7FFFFFFC, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
